// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared types and defaults for the multiply-stage sequencer
package mult_seq_pkg;

  localparam int DEF_LANES    = 7;
  localparam int DEF_BEATS    = 112;
  localparam int DEF_NEURONS  = 10;
  localparam int DEF_MEM_LAT  = 1;
  localparam int DEF_MULT_LAT = 2;

  // Neuron field is sized for the largest layer we expect; the top trims it.
  localparam int TAG_NEURON_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seqState_e;

  typedef struct packed {
    logic                    valid;
    logic                    first;
    logic                    last;
    logic [TAG_NEURON_W-1:0] neuron;
  } seqTag_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tag_delay_line.sv
// rtl/tag_delay_line.sv - fixed-depth shift register carrying beat tags alongside the datapath
module tag_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] stages [DEPTH];

  // Shift one stage per cycle; reset empties every stage so no stale tag survives an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= dataIn;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dataOut = stages[DEPTH-1];

endmodule

// File: rtl/mult_stage_sequencer.sv
// rtl/mult_stage_sequencer.sv - address sequencer and product tagging for one fully-connected layer pass
module mult_stage_sequencer
  import mult_seq_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int BEATS    = DEF_BEATS,
  parameter int NEURONS  = DEF_NEURONS,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int MULT_LAT = DEF_MULT_LAT
) (
  input  logic                                 clk,
  input  logic                                 GlobalReset,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [cntWidth(NEURONS*BEATS)-1:0]   w_addr,
  output logic [cntWidth(BEATS)-1:0]           p_addr,
  output logic                                 rd_en,
  output logic                                 acc_clear,
  output logic                                 acc_en,
  output logic                                 acc_last,
  output logic [cntWidth(NEURONS)-1:0]         neuron_idx
);

  localparam int P_ADDR_W = cntWidth(BEATS);
  localparam int NEURON_W = cntWidth(NEURONS);
  localparam int PIPE_LAT = MEM_LAT + MULT_LAT;
  localparam int DRAIN_W  = cntWidth(PIPE_LAT);

  if (LANES < 1 || BEATS < 1 || NEURONS < 1 || PIPE_LAT < 1 || NEURON_W > TAG_NEURON_W) begin : gBadParams
    $error("mult_stage_sequencer: unsupported parameter set");
  end

  seqState_e           state;
  logic [NEURON_W-1:0] neuron;
  logic [DRAIN_W-1:0]  drainCnt;
  seqTag_t             issueTag;
  seqTag_t             tagOut;
  logic                beatLast;
  logic                lastIssue;

  assign beatLast  = (p_addr == P_ADDR_W'(BEATS - 1));
  assign lastIssue = beatLast && (neuron == NEURON_W'(NEURONS - 1));

  // Pass control: issue one beat per cycle with no gaps, then wait out the pipeline before done.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      w_addr   <= '0;
      p_addr   <= '0;
      neuron   <= '0;
      drainCnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy   <= 1'b0;
          rd_en  <= 1'b0;
          w_addr <= '0;
          p_addr <= '0;
          neuron <= '0;
          if (start) begin
            state <= ISSUE;
            busy  <= 1'b1;
            rd_en <= 1'b1;
          end
        end
        ISSUE: begin
          if (lastIssue) begin
            state    <= DRAIN;
            rd_en    <= 1'b0;
            drainCnt <= DRAIN_W'(PIPE_LAT - 1);
          end else begin
            // Weight address runs linearly across neuron boundaries, so no multiply is needed.
            w_addr <= w_addr + 1'b1;
            if (beatLast) begin
              p_addr <= '0;
              neuron <= neuron + 1'b1;
            end else begin
              p_addr <= p_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drainCnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drainCnt <= drainCnt - 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          w_addr <= '0;
          p_addr <= '0;
          neuron <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag describing the beat whose addresses are on the bus this cycle; zero when nothing is issued.
  always_comb begin
    issueTag = '0;
    if (rd_en) begin
      issueTag.valid  = 1'b1;
      issueTag.first  = (p_addr == '0);
      issueTag.last   = beatLast;
      issueTag.neuron = TAG_NEURON_W'(neuron);
    end
  end

  tag_delay_line #(
    .DEPTH(PIPE_LAT),
    .WIDTH($bits(seqTag_t))
  ) uTagDelay (
    .clk    (clk),
    .rst    (GlobalReset),
    .dataIn (issueTag),
    .dataOut(tagOut)
  );

  assign acc_en     = tagOut.valid;
  assign acc_clear  = tagOut.first;
  assign acc_last   = tagOut.last;
  assign neuron_idx = tagOut.neuron[NEURON_W-1:0];

  if (NEURON_W < TAG_NEURON_W) begin : gTagHigh
    logic unusedTagHigh;
    assign unusedTagHigh = |tagOut.neuron[TAG_NEURON_W-1:NEURON_W];
  end

endmodule

// File: tb/tb_mult_stage_sequencer.sv
// tb/tb_mult_stage_sequencer.sv - scoreboard bench for the default and the one-beat sequencer
module tb_mult_stage_sequencer;

  localparam int LAT = 3;
  localparam int NP [2] = '{10, 2};
  localparam int BP [2] = '{112, 1};

  typedef struct {
    int cyc;
    int a;
    int b;
    int c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rstV [2];
  logic startV [2];

  logic        busy0, done0, rdEn0, clr0, en0, last0;
  logic [10:0] wAddr0;
  logic [6:0]  pAddr0;
  logic [3:0]  nIdx0;
  logic        busy1, done1, rdEn1, clr1, en1, last1;
  logic [0:0]  wAddr1;
  logic [0:0]  pAddr1;
  logic [0:0]  nIdx1;

  mult_stage_sequencer uBig (
    .clk(clk), .GlobalReset(rstV[0]), .start(startV[0]),
    .busy(busy0), .done(done0), .w_addr(wAddr0), .p_addr(pAddr0), .rd_en(rdEn0),
    .acc_clear(clr0), .acc_en(en0), .acc_last(last0), .neuron_idx(nIdx0)
  );

  mult_stage_sequencer #(.BEATS(1), .NEURONS(2)) uSmall (
    .clk(clk), .GlobalReset(rstV[1]), .start(startV[1]),
    .busy(busy1), .done(done1), .w_addr(wAddr1), .p_addr(pAddr1), .rd_en(rdEn1),
    .acc_clear(clr1), .acc_en(en1), .acc_last(last1), .neuron_idx(nIdx1)
  );

  int wI [2], pI [2], nI [2];
  int busyI [2], doneI [2], rdI [2], clrI [2], enI [2], lastI [2];
  assign wI[0] = int'(wAddr0);   assign wI[1] = int'(wAddr1);
  assign pI[0] = int'(pAddr0);   assign pI[1] = int'(pAddr1);
  assign nI[0] = int'(nIdx0);    assign nI[1] = int'(nIdx1);
  assign busyI[0] = int'(busy0); assign busyI[1] = int'(busy1);
  assign doneI[0] = int'(done0); assign doneI[1] = int'(done1);
  assign rdI[0] = int'(rdEn0);   assign rdI[1] = int'(rdEn1);
  assign clrI[0] = int'(clr0);   assign clrI[1] = int'(clr1);
  assign enI[0] = int'(en0);     assign enI[1] = int'(en1);
  assign lastI[0] = int'(last0); assign lastI[1] = int'(last1);

  exp_t issQ [2][$];
  exp_t tagQ [2][$];
  int   doneQ [2][$];
  int   freeAt [2];
  int   busyFrom [2];
  int   busyTo [2];

  int checks = 0;
  int errors = 0;

  task automatic check(input int k, input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL inst%0d %s: got %0d expected %0d at cycle %0d", k, name, act, expv, cyc);
    end
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Reference model: an accepted start at cycle s yields a gapless sweep of neuron*BEATS+beat addresses,
  // each product tag LAT cycles after its issue, and done one cycle after the final product.
  task automatic pulseStart(input int k);
    int s;
    if (cyc >= freeAt[k] && !rstV[k]) begin
      s = cyc;
      for (int n = 0; n < NP[k]; n++) begin
        for (int b = 0; b < BP[k]; b++) begin
          issQ[k].push_back('{s + 1 + n * BP[k] + b, n * BP[k] + b, b, 0});
          tagQ[k].push_back('{s + 1 + n * BP[k] + b + LAT, int'(b == 0), int'(b == BP[k] - 1), n});
        end
      end
      doneQ[k].push_back(s + NP[k] * BP[k] + LAT + 1);
      busyFrom[k] = s + 1;
      busyTo[k]   = s + NP[k] * BP[k] + LAT + 1;
      freeAt[k]   = busyTo[k] + 1;
    end
    startV[k] = 1'b1;
    @(negedge clk);
    startV[k] = 1'b0;
  endtask

  task automatic applyReset(input int k, input int len);
    @(posedge clk);
    #1;
    rstV[k] = 1'b1;
    issQ[k].delete();
    tagQ[k].delete();
    doneQ[k].delete();
    busyFrom[k] = 0;
    busyTo[k]   = -1;
    freeAt[k]   = 0;
    repeat (len) @(posedge clk);
    #1;
    rstV[k] = 1'b0;
  endtask

  exp_t e;
  int   d;

  // Monitor: compares every presented address, product tag and done against the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rstV[k]) begin
        check(k, "reset_ctl", busyI[k] + doneI[k] + rdI[k], 0);
        check(k, "reset_tag", clrI[k] + enI[k] + lastI[k] + nI[k], 0);
        check(k, "reset_addr", wI[k] + pI[k], 0);
      end else begin
        check(k, "busy", busyI[k], int'(cyc >= busyFrom[k] && cyc <= busyTo[k]));
        if (rdI[k] != 0) begin
          if (issQ[k].size() == 0) begin
            check(k, "rd_en_unexpected", rdI[k], 0);
          end else begin
            e = issQ[k].pop_front();
            check(k, "issue_cycle", cyc, e.cyc);
            check(k, "w_addr", wI[k], e.a);
            check(k, "p_addr", pI[k], e.b);
          end
        end
        if (enI[k] != 0) begin
          if (tagQ[k].size() == 0) begin
            check(k, "acc_en_unexpected", enI[k], 0);
          end else begin
            e = tagQ[k].pop_front();
            check(k, "tag_cycle", cyc, e.cyc);
            check(k, "acc_clear", clrI[k], e.a);
            check(k, "acc_last", lastI[k], e.b);
            check(k, "neuron_idx", nI[k], e.c);
          end
        end else begin
          check(k, "tag_quiet", clrI[k] + lastI[k], 0);
        end
        if (doneI[k] != 0) begin
          if (doneQ[k].size() == 0) begin
            check(k, "done_unexpected", doneI[k], 0);
          end else begin
            d = doneQ[k].pop_front();
            check(k, "done_cycle", cyc, d);
          end
        end
      end
    end
  end

  task automatic runBig();
    int s0;
    int s1;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    s0 = cyc;
    pulseStart(0);
    waitUntil(s0 + 5);
    pulseStart(0);
    waitUntil(s0 + 1124);
    pulseStart(0);
    waitUntil(s0 + 1125);
    s1 = cyc;
    pulseStart(0);
    for (int i = 0; i < 3; i++) begin
      waitUntil(cyc + $urandom_range(20, 120));
      pulseStart(0);
    end
    waitUntil(s1 + 499);
    applyReset(0, 2);
    repeat ($urandom_range(1, 5)) @(negedge clk);
    pulseStart(0);
    waitUntil(freeAt[0] + 2);
  endtask

  task automatic runSmall();
    for (int i = 0; i < 6; i++) begin
      waitUntil(freeAt[1] + $urandom_range(0, 3));
      pulseStart(1);
      if ($urandom_range(0, 1) == 1) begin
        waitUntil(freeAt[1] - 1);
        pulseStart(1);
      end
    end
    waitUntil(freeAt[1] + 1);
    pulseStart(1);
    waitUntil(cyc + 1);
    applyReset(1, 1);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    pulseStart(1);
    waitUntil(freeAt[1] + 2);
  endtask

  initial begin
    rstV[0] = 1'b1;
    rstV[1] = 1'b1;
    startV[0] = 1'b0;
    startV[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      freeAt[k]   = 0;
      busyFrom[k] = 0;
      busyTo[k]   = -1;
    end
    repeat (3) @(posedge clk);
    #1;
    rstV[0] = 1'b0;
    rstV[1] = 1'b0;
    @(negedge clk);
    fork
      runBig();
      runSmall();
    join
    for (int t = 0; t < 3000; t++) begin
      if (issQ[0].size() + tagQ[0].size() + doneQ[0].size() +
          issQ[1].size() + tagQ[1].size() + doneQ[1].size() == 0) break;
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      check(k, "issues_left", issQ[k].size(), 0);
      check(k, "tags_left", tagQ[k].size(), 0);
      check(k, "dones_left", doneQ[k].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
